mac_adc_capture: RTL

- Downstream consumer of the RRAM controller's MAC phase.
- Sequences one MAC job per `start`: for each input vector it requests the wordlines, waits for settle, strobes the ADC bank, then samples the 3-comparator thermometer code of 8 columns.
- Converts each code to a 2-bit value and accumulates per column over up to 16 vectors.
- Writes the packed column sums as two 32-bit words into the output buffer's write port.

---
 rtl/mac_pkg.sv | 35 +++
 rtl/therm2bin.sv | 34 +++
 rtl/mac_adc_capture.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC ADC capture block.
// Feature macro ADC_THERM_BUBBLE_FIX_EN is consumed by therm2bin, not here.
package mac_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_REQ     = 4'd1,
    ST_SETTLE  = 4'd2,
    ST_STROBE  = 4'd3,
    ST_WAIT    = 4'd4,
    ST_CAPTURE = 4'd5,
    ST_WR0     = 4'd6,
    ST_WR1     = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  localparam logic [1:0] STROBE_NONE = 2'b00;
  localparam logic [1:0] STROBE_LO   = 2'b01;
  localparam logic [1:0] STROBE_HI   = 2'b10;

  localparam logic [4:0] MAX_VECTORS = 5'd16;

  // Four 8-bit column fields per 32-bit output word, column 0 in the low byte.
  localparam int FIELD_W         = 8;
  localparam int FIELDS_PER_WORD = 4;

  function automatic logic [4:0] clamp_vectors(input logic [4:0] n);
    if ((n == 5'd0) || (n > MAX_VECTORS)) begin
      clamp_vectors = MAX_VECTORS;
    end else begin
      clamp_vectors = n;
    end
  endfunction

endpackage

// File: rtl/therm2bin.sv
// 3-comparator thermometer code to 2-bit value converter.
// ADC_THERM_BUBBLE_FIX_EN selects bubble-tolerant decoding with an invalid-code flag.
module therm2bin (
  input  logic [2:0] code,
  output logic [1:0] value,
  output logic       invalid
);

`ifdef ADC_THERM_BUBBLE_FIX_EN
  // Bubbled codes are resolved to the highest set comparator.
  always_comb begin
    value   = 2'd0;
    invalid = 1'b0;
    case (code)
      3'b000:  begin value = 2'd0; invalid = 1'b0; end
      3'b001:  begin value = 2'd1; invalid = 1'b0; end
      3'b011:  begin value = 2'd2; invalid = 1'b0; end
      3'b111:  begin value = 2'd3; invalid = 1'b0; end
      3'b010:  begin value = 2'd2; invalid = 1'b1; end
      3'b100:  begin value = 2'd3; invalid = 1'b1; end
      3'b101:  begin value = 2'd3; invalid = 1'b1; end
      3'b110:  begin value = 2'd3; invalid = 1'b1; end
      default: begin value = 2'd0; invalid = 1'b0; end
    endcase
  end
`else
  // Plain popcount; code validity is not tracked.
  always_comb begin
    value   = {1'b0, code[0]} + {1'b0, code[1]} + {1'b0, code[2]};
    invalid = 1'b0;
  end
`endif

endmodule

// File: rtl/mac_adc_capture.sv
// MAC job sequencer: wordline request, settle, ADC strobe, capture, per-column accumulate, 2-word writeback.
// Optional macro ADC_THERM_BUBBLE_FIX_EN enables bubble-tolerant decoding and therm_err.
module mac_adc_capture
  import mac_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ADC_LATENCY   = 1,
  parameter int NUM_COLS      = 8,
  parameter int ACC_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  num_vectors,
  input  logic        col_half,
  input  logic [5:0]  ob_base_addr,
  output logic        vec_req,
  input  logic        vec_ack,
  input  logic [15:0] ADC_OUT0,
  input  logic [15:0] ADC_OUT1,
  input  logic [15:0] ADC_OUT2,
  output logic [1:0]  clk_en_adc,
  output logic        ob_wr_en,
  output logic [5:0]  ob_addr,
  output logic [31:0] ob_data,
  output logic        busy,
  output logic        done,
  output logic        therm_err
);

  localparam int CNT_W = 8;

  state_t             state_r, state_nxt;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt;
  logic [4:0]         rem_r, rem_nxt;
  logic               half_r, half_nxt;
  logic [5:0]         base_r, base_nxt;
  logic               err_r, err_nxt;
  logic [ACC_W-1:0]   acc_r [NUM_COLS];
  logic [ACC_W-1:0]   acc_nxt [NUM_COLS];
  logic [1:0]         val_s [NUM_COLS];
  logic [NUM_COLS-1:0] inv_s;

  logic               vec_req_nxt, wr_en_nxt, busy_nxt, done_nxt;
  logic [1:0]         clk_en_nxt;
  logic [5:0]         addr_nxt;
  logic [31:0]        data_nxt;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [2:0] code_s;
    assign code_s = half_r ? {ADC_OUT2[c+NUM_COLS], ADC_OUT1[c+NUM_COLS], ADC_OUT0[c+NUM_COLS]}
                           : {ADC_OUT2[c], ADC_OUT1[c], ADC_OUT0[c]};
    therm2bin u_therm2bin (.code(code_s), .value(val_s[c]), .invalid(inv_s[c]));
  end

  // Next-state, datapath and job-field update.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    rem_nxt   = rem_r;
    half_nxt  = half_r;
    base_nxt  = base_r;
    err_nxt   = err_r;
    for (int c = 0; c < NUM_COLS; c++) acc_nxt[c] = acc_r[c];

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_REQ;
          half_nxt  = col_half;
          base_nxt  = ob_base_addr;
          rem_nxt   = clamp_vectors(num_vectors);
          err_nxt   = 1'b0;
          for (int c = 0; c < NUM_COLS; c++) acc_nxt[c] = {ACC_W{1'b0}};
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (vec_ack) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES);
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_nxt = ST_STROBE;
        end else begin
          cnt_nxt = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STROBE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(ADC_LATENCY);
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_nxt = ST_CAPTURE;
        end else begin
          cnt_nxt = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          for (int c = 0; c < NUM_COLS; c++) acc_nxt[c] = acc_r[c] + ACC_W'(val_s[c]);
          err_nxt   = err_r | (|inv_s);
          rem_nxt   = rem_r - 5'd1;
          state_nxt = (rem_r == 5'd1) ? ST_WR0 : ST_REQ;
        end
      end
      // Writeback is not abortable so the buffer never holds half a result.
      ST_WR0:  state_nxt = ST_WR1;
      ST_WR1:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    vec_req_nxt = (state_nxt == ST_REQ);
    busy_nxt    = (state_nxt != ST_IDLE);
    done_nxt    = (state_nxt == ST_DONE);
    wr_en_nxt   = (state_nxt == ST_WR0) || (state_nxt == ST_WR1);
    clk_en_nxt  = STROBE_NONE;
    addr_nxt    = 6'd0;
    data_nxt    = 32'd0;
    if (state_nxt == ST_STROBE) begin
      clk_en_nxt = half_nxt ? STROBE_HI : STROBE_LO;
    end else begin
      clk_en_nxt = STROBE_NONE;
    end
    if (state_nxt == ST_WR0) begin
      addr_nxt = base_nxt;
      for (int f = 0; f < FIELDS_PER_WORD; f++)
        data_nxt[f*FIELD_W +: FIELD_W] = FIELD_W'(acc_nxt[f]);
    end else if (state_nxt == ST_WR1) begin
      addr_nxt = base_nxt + 6'd1;
      for (int f = 0; f < FIELDS_PER_WORD; f++)
        data_nxt[f*FIELD_W +: FIELD_W] = FIELD_W'(acc_nxt[f+FIELDS_PER_WORD]);
    end else begin
      addr_nxt = 6'd0;
      data_nxt = 32'd0;
    end
  end

  // State, job context and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      rem_r      <= 5'd0;
      half_r     <= 1'b0;
      base_r     <= 6'd0;
      err_r      <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) acc_r[c] <= {ACC_W{1'b0}};
      vec_req    <= 1'b0;
      clk_en_adc <= 2'b00;
      ob_wr_en   <= 1'b0;
      ob_addr    <= 6'd0;
      ob_data    <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      rem_r      <= rem_nxt;
      half_r     <= half_nxt;
      base_r     <= base_nxt;
      err_r      <= err_nxt;
      for (int c = 0; c < NUM_COLS; c++) acc_r[c] <= acc_nxt[c];
      vec_req    <= vec_req_nxt;
      clk_en_adc <= clk_en_nxt;
      ob_wr_en   <= wr_en_nxt;
      ob_addr    <= addr_nxt;
      ob_data    <= data_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  assign therm_err = err_r;

endmodule
